// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if
//  Bundles the two writeback request channels (ALU, MEM) and the shared
//  register-file write port.
//  Signals:
//    alu_valid/alu_rd/alu_wd, alu_ready : ALU writeback request + accept
//    mem_valid/mem_rd/mem_wd, mem_ready : MEM (load) writeback request + accept
//    rf_we/rf_rd/rf_wd/rf_src           : registered regfile write port
//  Modports:
//    slave  : arbiter side (takes requests, drives readies and rf port)
//    master : requester / regfile side
interface regfile_wb_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_wd;
  logic              alu_ready;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_wd;
  logic              mem_ready;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_wd;
  logic              rf_src;

  modport slave (
    input  alu_valid, alu_rd, alu_wd,
    input  mem_valid, mem_rd, mem_wd,
    output alu_ready, mem_ready,
    output rf_we, rf_rd, rf_wd, rf_src
  );

  modport master (
    output alu_valid, alu_rd, alu_wd,
    output mem_valid, mem_rd, mem_wd,
    input  alu_ready, mem_ready,
    input  rf_we, rf_rd, rf_wd, rf_src
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//  Shares the single register-file write port between the ALU and MEM
//  writeback sources. MEM has fixed priority; an anti-starvation FSM hands
//  priority to the ALU after STARVE_MAX consecutive lost ALU cycles.
//  One write per cycle, write port registered (latency 1).
//  Ports:
//    clk       : clock, rising edge
//    rst_n     : asynchronous active-low reset
//    hold      : freeze writeback (no grants, FSM frozen, stalls still counted)
//    bus       : request channels + regfile write port (slave modport)
//    stall_cnt : saturating count of cycles with any valid-but-not-accepted request
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned STARVE_MAX = 3,
  parameter int unsigned STALL_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hold,
  regfile_wb_arbiter_if.slave  bus,
  output logic [STALL_W-1:0]   stall_cnt
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  // starve value at which one more lost cycle hands priority to the ALU
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);

  typedef enum logic {
    MEM_PRIO = 1'b0,
    ALU_PRIO = 1'b1
  } state_t;

  state_t            state;
  logic [SW-1:0]     starve;
  logic              alu_ready_c;
  logic              mem_ready_c;
  logic              stall_evt;

  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_rd_q;
  logic [DATA_W-1:0] rf_wd_q;
  logic              rf_src_q;
  logic [STALL_W-1:0] stall_q;

  // Grant: a ready is only ever raised for a valid requester, so ready alone
  // marks a transfer.
  always_comb begin
    alu_ready_c = 1'b0;
    mem_ready_c = 1'b0;
    if (!hold) begin
      if (state == MEM_PRIO) begin
        mem_ready_c = bus.mem_valid;
        alu_ready_c = bus.alu_valid & ~bus.mem_valid;
      end else begin
        alu_ready_c = bus.alu_valid;
        mem_ready_c = bus.mem_valid & ~bus.alu_valid;
      end
    end
  end

  always_comb begin
    stall_evt = (bus.alu_valid & ~alu_ready_c) | (bus.mem_valid & ~mem_ready_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MEM_PRIO;
      starve   <= '0;
      rf_we_q  <= 1'b0;
      rf_rd_q  <= '0;
      rf_wd_q  <= '0;
      rf_src_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      // Write port: x0 transfers complete the handshake but never write.
      rf_we_q <= 1'b0;
      if (alu_ready_c) begin
        rf_we_q  <= |bus.alu_rd;
        rf_rd_q  <= bus.alu_rd;
        rf_wd_q  <= bus.alu_wd;
        rf_src_q <= 1'b0;
      end else if (mem_ready_c) begin
        rf_we_q  <= |bus.mem_rd;
        rf_rd_q  <= bus.mem_rd;
        rf_wd_q  <= bus.mem_wd;
        rf_src_q <= 1'b1;
      end

      if (stall_evt && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end

      if (!hold) begin
        case (state)
          MEM_PRIO: begin
            if (alu_ready_c) begin
              starve <= '0;
            end else if (bus.alu_valid) begin
              if (starve == STARVE_LAST) begin
                starve <= '0;
                state  <= ALU_PRIO;
              end else begin
                starve <= starve + 1'b1;
              end
            end
          end
          ALU_PRIO: begin
            if (alu_ready_c || !bus.alu_valid) begin
              starve <= '0;
              state  <= MEM_PRIO;
            end
          end
          default: begin
            starve <= '0;
            state  <= MEM_PRIO;
          end
        endcase
      end
    end
  end

  assign bus.alu_ready = alu_ready_c;
  assign bus.mem_ready = mem_ready_c;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_rd     = rf_rd_q;
  assign bus.rf_wd     = rf_wd_q;
  assign bus.rf_src    = rf_src_q;
  assign stall_cnt     = stall_q;

endmodule
